// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states and the
// nine-bit stage-control bundle with its canned settings.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN = 2'b00,
    FU  = 2'b01,
    MEM = 2'b10
  } state_e;

  // One enable/flush pair per stage register, plus the PC enable.
  typedef struct packed {
    logic pc_en;
    logic fd_en;
    logic fd_flush;
    logic de_en;
    logic de_flush;
    logic em_en;
    logic em_flush;
    logic mw_en;
    logic mw_flush;
  } stage_ctrl_t;

  // Everything advances, nothing is squashed.
  localparam stage_ctrl_t NORMAL         = 9'b1_1_0_1_0_1_0_1_0;
  // Dmem wait: hold IF..EX/MEM, keep pushing bubbles into WB.
  localparam stage_ctrl_t FREEZE_ALL     = 9'b0_0_0_0_0_0_0_1_1;
  // Mul/div in EX: hold IF..ID/EX, bubble into MEM, MEM/WB drains.
  localparam stage_ctrl_t FU_STALL       = 9'b0_0_0_0_0_1_1_1_0;
  // Load-use: hold PC and IF/ID, bubble into EX.
  localparam stage_ctrl_t LOAD_USE_STALL = 9'b0_0_0_1_1_1_0_1_0;
  // Taken branch: squash the wrong-path fetch, PC loads the target.
  localparam stage_ctrl_t BRANCH_FLUSH   = 9'b1_1_1_1_0_1_0_1_0;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard-request / stage-control bundle between the pipeline datapath and
// the stall sequencer. master = datapath side, slave = sequencer.
interface pipe_stall_ctrl_if;
  logic load_use_ID;
  logic branch_taken_ID;
  logic fu_start_EX;
  logic dmem_req_MEM;
  logic dmem_ready;
  logic PC_EN_IF;
  logic reg_FD_EN;
  logic reg_FD_flush;
  logic reg_DE_EN;
  logic reg_DE_flush;
  logic reg_EM_EN;
  logic reg_EM_flush;
  logic reg_MW_EN;
  logic reg_MW_flush;
  logic fu_busy;
  logic mem_err;

  modport master (
    output load_use_ID, branch_taken_ID, fu_start_EX, dmem_req_MEM, dmem_ready,
    input  PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_EN, reg_DE_flush,
           reg_EM_EN, reg_EM_flush, reg_MW_EN, reg_MW_flush, fu_busy, mem_err
  );

  modport slave (
    input  load_use_ID, branch_taken_ID, fu_start_EX, dmem_req_MEM, dmem_ready,
    output PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_EN, reg_DE_flush,
           reg_EM_EN, reg_EM_flush, reg_MW_EN, reg_MW_flush, fu_busy, mem_err
  );
endinterface

// File: rtl/pipe_stall_ctrl_cnt.sv
// stall_cnt: loadable up/down counter. Counting up saturates at LIM,
// counting down stops at 0; at_lim_o flags cnt == LIM.
// Priority: clear > load > up > down.
module stall_cnt #(
  parameter int W   = 8,
  parameter int LIM = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         up_i,
  input  logic         dn_i,
  output logic         at_lim_o
);
  localparam logic [W-1:0] LIMV = W'(LIM);

  logic [W-1:0] cnt_q, cnt_d;

  // next count
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                        cnt_d = '0;
    else if (ld_i)                    cnt_d = ld_val_i;
    else if (up_i && cnt_q != LIMV)   cnt_d = cnt_q + W'(1);
    else if (dn_i && cnt_q != '0)     cnt_d = cnt_q - W'(1);
  end

  // count register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign at_lim_o = (cnt_q == LIMV);
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: stall/flush sequencer for the IF/ID/EX/MEM/WB pipeline.
// Arbitrates dmem wait > mul/div start > load-use > taken branch, and tracks
// the multi-cycle mul/div and dmem-wait conditions with a small FSM.
// Optional: define STALL_PERF_CNT_EN to add stall/flush performance counters.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FU_LAT      = 8,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  pipe_stall_ctrl_if.slave    pif
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0]         perf_stall_cycles,
  output logic [31:0]         perf_flush_cnt
`endif
);
  localparam int             MEM_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [7:0]     FU_LD = 8'(FU_LAT - 1);

  state_e      state_q, state_d;
  stage_ctrl_t run_ctrl, ctrl, ctrl_o;
  logic        run_fu;
  logic        fu_ld, fu_dn, fu_last;
  logic        mem_ld, mem_up, mem_clr, mem_lim;
  logic        mem_err_q;

  // Normal-run priorities below the dmem wait; reused when MEM releases.
  always_comb begin
    run_ctrl = NORMAL;
    run_fu   = 1'b0;
    if (pif.fu_start_EX) begin
      run_ctrl = FU_STALL;
      run_fu   = 1'b1;
    end else if (pif.load_use_ID) begin
      // a coincident branch is dropped; ID holds, so it is seen again next cycle
      run_ctrl = LOAD_USE_STALL;
    end else if (pif.branch_taken_ID) begin
      run_ctrl = BRANCH_FLUSH;
    end
  end

  // FSM next state, stage controls and counter commands
  always_comb begin
    state_d = state_q;
    ctrl    = NORMAL;
    fu_ld   = 1'b0;
    fu_dn   = 1'b0;
    mem_ld  = 1'b0;
    mem_up  = 1'b0;
    mem_clr = 1'b0;
    unique case (state_q)
      FU: begin
        // every FU cycle stalls; the counter hitting 1 hands back to RUN so
        // the following cycle is the first normal one
        ctrl  = FU_STALL;
        fu_dn = 1'b1;
        if (fu_last) state_d = RUN;
      end
      MEM: begin
        if (!pif.dmem_ready) begin
          ctrl   = FREEZE_ALL;
          mem_up = 1'b1;
        end else begin
          ctrl    = run_ctrl;
          fu_ld   = run_fu;
          mem_clr = 1'b1;
          state_d = run_fu ? FU : RUN;
        end
      end
      default: begin
        if (pif.dmem_req_MEM && !pif.dmem_ready) begin
          ctrl    = FREEZE_ALL;
          mem_ld  = 1'b1;
          state_d = MEM;
        end else begin
          ctrl    = run_ctrl;
          fu_ld   = run_fu;
          state_d = run_fu ? FU : RUN;
        end
      end
    endcase
  end

  // state register and sticky dmem timeout flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= RUN;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_err_q <= mem_err_q | mem_lim;
    end

  // mul/div occupancy: loaded with FU_LAT-1, terminal count 1
  stall_cnt #(.W(8), .LIM(1)) u_fu_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (1'b0),
    .ld_i     (fu_ld),
    .ld_val_i (FU_LD),
    .up_i     (1'b0),
    .dn_i     (fu_dn),
    .at_lim_o (fu_last)
  );

  // dmem wait length, saturating at the timeout
  stall_cnt #(.W(MEM_W), .LIM(MEM_TIMEOUT)) u_mem_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (mem_clr),
    .ld_i     (mem_ld),
    .ld_val_i (MEM_W'(1)),
    .up_i     (mem_up),
    .dn_i     (1'b0),
    .at_lim_o (mem_lim)
  );

  // reset forces every enable low, independent of the clock
  always_comb ctrl_o = rst_n ? ctrl : '0;

  assign pif.PC_EN_IF     = ctrl_o.pc_en;
  assign pif.reg_FD_EN    = ctrl_o.fd_en;
  assign pif.reg_FD_flush = ctrl_o.fd_flush;
  assign pif.reg_DE_EN    = ctrl_o.de_en;
  assign pif.reg_DE_flush = ctrl_o.de_flush;
  assign pif.reg_EM_EN    = ctrl_o.em_en;
  assign pif.reg_EM_flush = ctrl_o.em_flush;
  assign pif.reg_MW_EN    = ctrl_o.mw_en;
  assign pif.reg_MW_flush = ctrl_o.mw_flush;
  assign pif.fu_busy      = rst_n & (state_q == FU);
  // the flag shows in the same cycle the wait count reaches the limit
  assign pif.mem_err      = rst_n & (mem_err_q | mem_lim);

`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  // free-running, wrapping event counters
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (!ctrl_o.pc_en)                      perf_stall_q <= perf_stall_q + 32'd1;
      if (ctrl_o.fd_flush || ctrl_o.de_flush) perf_flush_q <= perf_flush_q + 32'd1;
    end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_cnt    = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl. Two instances share the request inputs:
// u_dut (defaults, MEM_TIMEOUT=64) and u_dut_to (MEM_TIMEOUT=4, timeout case).
module tb_pipe_stall_ctrl;
  // control vector order: PC, FD_EN, FD_fl, DE_EN, DE_fl, EM_EN, EM_fl, MW_EN, MW_fl
  localparam logic [8:0] C_NORM = 9'b110101010;
  localparam logic [8:0] C_FRZ  = 9'b000000011;
  localparam logic [8:0] C_FUS  = 9'b000001110;
  localparam logic [8:0] C_LU   = 9'b000111010;
  localparam logic [8:0] C_BR   = 9'b111101010;
  localparam logic [8:0] C_ZERO = 9'b000000000;

  typedef struct {
    string      nm;
    logic       lu, br, fs, req, rdy;
    logic [8:0] c;
    logic       busy, err, chkb, errb;
  } vec_t;

  logic clk, rst_n;
  int   nvec = 0;
  int   nerr = 0;
  vec_t sb[$];
  vec_t tbl[9];

  pipe_stall_ctrl_if ifa ();
  pipe_stall_ctrl_if ifb ();

  assign ifb.load_use_ID     = ifa.load_use_ID;
  assign ifb.branch_taken_ID = ifa.branch_taken_ID;
  assign ifb.fu_start_EX     = ifa.fu_start_EX;
  assign ifb.dmem_req_MEM    = ifa.dmem_req_MEM;
  assign ifb.dmem_ready      = ifa.dmem_ready;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] ps_a, pf_a, ps_b, pf_b;
`endif

  pipe_stall_ctrl #(.FU_LAT(8), .MEM_TIMEOUT(64)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pif   (ifa)
`ifdef STALL_PERF_CNT_EN
    , .perf_stall_cycles (ps_a), .perf_flush_cnt (pf_a)
`endif
  );

  pipe_stall_ctrl #(.FU_LAT(8), .MEM_TIMEOUT(4)) u_dut_to (
    .clk   (clk),
    .rst_n (rst_n),
    .pif   (ifb)
`ifdef STALL_PERF_CNT_EN
    , .perf_stall_cycles (ps_b), .perf_flush_cnt (pf_b)
`endif
  );

  logic [8:0] ca, cb;
  assign ca = {ifa.PC_EN_IF, ifa.reg_FD_EN, ifa.reg_FD_flush, ifa.reg_DE_EN, ifa.reg_DE_flush,
               ifa.reg_EM_EN, ifa.reg_EM_flush, ifa.reg_MW_EN, ifa.reg_MW_flush};
  assign cb = {ifb.PC_EN_IF, ifb.reg_FD_EN, ifb.reg_FD_flush, ifb.reg_DE_EN, ifb.reg_DE_flush,
               ifb.reg_EM_EN, ifb.reg_EM_flush, ifb.reg_MW_EN, ifb.reg_MW_flush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [8:0] act, input logic [8:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic lu, br, fs, req, rdy,
                              input logic [8:0] c, input logic busy, err,
                              input logic chkb = 1'b0, input logic errb = 1'b0);
    vec_t v;
    v.nm = nm; v.lu = lu; v.br = br; v.fs = fs; v.req = req; v.rdy = rdy;
    v.c = c; v.busy = busy; v.err = err; v.chkb = chkb; v.errb = errb;
    return v;
  endfunction

  // drive one cycle of requests and queue what the controller should show
  task automatic drive(input vec_t v);
    @(posedge clk); #1;
    ifa.load_use_ID     = v.lu;
    ifa.branch_taken_ID = v.br;
    ifa.fu_start_EX     = v.fs;
    ifa.dmem_req_MEM    = v.req;
    ifa.dmem_ready      = v.rdy;
    sb.push_back(v);
  endtask

  // monitor: pop the expectation for this cycle, mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      vec_t e;
      e = sb.pop_front();
      cmp({e.nm, ".ctrl"}, ca, e.c);
      cmp({e.nm, ".fu_busy"}, {8'b0, ifa.fu_busy}, {8'b0, e.busy});
      cmp({e.nm, ".mem_err"}, {8'b0, ifa.mem_err}, {8'b0, e.err});
      if (e.chkb) begin
        cmp({e.nm, ".to.ctrl"}, cb, e.c);
        cmp({e.nm, ".to.mem_err"}, {8'b0, ifb.mem_err}, {8'b0, e.errb});
      end
    end
  end

  task automatic chk_reset_state(input string nm);
    cmp({nm, ".ctrl"}, ca, C_ZERO);
    cmp({nm, ".fu_busy"}, {8'b0, ifa.fu_busy}, 9'd0);
    cmp({nm, ".mem_err"}, {8'b0, ifa.mem_err}, 9'd0);
    cmp({nm, ".to.mem_err"}, {8'b0, ifb.mem_err}, 9'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk("idle",         0, 0, 0, 0, 0, C_NORM, 0, 0);
    tbl[1] = mk("load_use",     1, 0, 0, 0, 0, C_LU,   0, 0);
    tbl[2] = mk("branch",       0, 1, 0, 0, 0, C_BR,   0, 0);
    tbl[3] = mk("lu_and_br",    1, 1, 0, 0, 0, C_LU,   0, 0);
    tbl[4] = mk("br_retry",     0, 1, 0, 0, 0, C_BR,   0, 0);
    tbl[5] = mk("dmem_0wait",   0, 0, 0, 1, 1, C_NORM, 0, 0);
    tbl[6] = mk("dmem_0w_br",   0, 1, 0, 1, 1, C_BR,   0, 0);
    tbl[7] = mk("dmem_0w_lubr", 1, 1, 0, 1, 1, C_LU,   0, 0);
    tbl[8] = mk("idle2",        0, 0, 0, 0, 0, C_NORM, 0, 0);

    rst_n = 1'b0;
    ifa.load_use_ID = 0; ifa.branch_taken_ID = 0; ifa.fu_start_EX = 0;
    ifa.dmem_req_MEM = 0; ifa.dmem_ready = 0;
    repeat (3) @(posedge clk);
    #2 chk_reset_state("reset");

    // release: normal outputs straight away
    @(posedge clk); #1 rst_n = 1'b1;
    #1 cmp("release.ctrl", ca, C_NORM);

    // single-cycle priority table
    for (int i = 0; i < 9; i++) drive(tbl[i]);

    // mul/div: 8 stall cycles, busy on the last 7, other requests ignored
    drive(mk("fu_start", 0, 0, 1, 0, 0, C_FUS, 0, 0));
    for (int i = 0; i < 7; i++)
      drive(mk($sformatf("fu_busy%0d", i), 1'(i % 2), 1'(i % 3 == 0), 1'(i == 3), 0, 0,
               C_FUS, 1, 0));
    drive(mk("fu_done", 0, 0, 0, 0, 0, C_NORM, 0, 0));

    // dmem wait: request cycle plus 3 MEM cycles frozen, release on ready
    drive(mk("mem_req", 0, 0, 0, 1, 0, C_FRZ, 0, 0));
    for (int i = 0; i < 3; i++)
      drive(mk($sformatf("mem_wait%0d", i), 0, 0, 0, 1, 0, C_FRZ, 0, 0));
    drive(mk("mem_ready", 0, 0, 0, 1, 1, C_NORM, 0, 0));
    drive(mk("mem_after", 0, 0, 0, 0, 0, C_NORM, 0, 0));

    // dmem wait beats mul/div, which then runs its full latency
    drive(mk("memfu_req", 0, 0, 1, 1, 0, C_FRZ, 0, 0));
    drive(mk("memfu_wait", 0, 0, 1, 1, 0, C_FRZ, 0, 0));
    drive(mk("memfu_rdy", 0, 0, 1, 1, 1, C_FUS, 0, 0));
    for (int i = 0; i < 7; i++)
      drive(mk($sformatf("memfu_busy%0d", i), 0, 0, 0, 0, 0, C_FUS, 1, 0));
    drive(mk("memfu_done", 0, 0, 0, 0, 0, C_NORM, 0, 0));

    // reset in cycle 3 of a mul/div aborts it at once
    drive(mk("rstfu_start", 0, 0, 1, 0, 0, C_FUS, 0, 0));
    drive(mk("rstfu_c2", 0, 0, 0, 0, 0, C_FUS, 1, 0));
    @(posedge clk); #1;
    cmp("rstfu_c3.fu_busy", {8'b0, ifa.fu_busy}, 9'd1);
    rst_n = 1'b0;
    #1 chk_reset_state("rstfu_inreset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 cmp("rstfu_release.ctrl", ca, C_NORM);
    drive(mk("rstfu_run", 0, 0, 0, 0, 0, C_NORM, 0, 0, 1, 0));

    // timeout on the MEM_TIMEOUT=4 instance: error from the 5th wait cycle
    for (int k = 0; k < 10; k++)
      drive(mk($sformatf("to_wait%0d", k), 0, 0, 0, 1, 0, C_FRZ, 0, 0, 1, 1'(k >= 4)));
    drive(mk("to_ready", 0, 0, 0, 1, 1, C_NORM, 0, 0, 1, 1));
    for (int k = 0; k < 3; k++)
      drive(mk($sformatf("to_sticky%0d", k), 0, 1'(k == 1), 0, 0, 0,
               (k == 1) ? C_BR : C_NORM, 0, 0, 1, 1));
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1 chk_reset_state("to_reset");

    if (sb.size() != 0) begin
      nvec++; nerr++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
